// File: rtl/pcs25g_train_pkg.sv
// Shared PCS training-preamble definitions, used by the RX detector and the TX preamble generator.
package pcs25g_train_pkg;

  localparam int LANE_W = 48;

  localparam logic [LANE_W-1:0] ESC_CHAR  = 48'hE5C0_3A1F_E5C0;
  localparam logic [LANE_W-1:0] IDLE_CHAR = 48'h0707_0707_0707;
  // A SYNC lane carries SYNC_CHAR in its upper 37 bits; the low 11 bits must be zero
  localparam logic [36:0]       SYNC_CHAR = 37'h1_5A5A_C3C3;

  typedef enum logic [1:0] {
    W_ESC   = 2'd0,
    W_IDLE  = 2'd1,
    W_SYNC  = 2'd2,
    W_OTHER = 2'd3
  } word_class_e;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    ESC_S  = 3'd1,
    IDLE_S = 3'd2,
    SYNC_S = 3'd3,
    LOCKED = 3'd4
  } state_e;

endpackage

// File: rtl/train_word_classify192.sv
// Combinational classifier: 4-lane training word -> ESC / IDLE / SYNC / OTHER.
module train_word_classify192 #(
  parameter int LANE_W = pcs25g_train_pkg::LANE_W
) (
  input  logic [4*LANE_W-1:0]           data,
  output pcs25g_train_pkg::word_class_e wclass
);
  import pcs25g_train_pkg::*;

  logic [3:0] is_esc;
  logic [3:0] is_idle;
  logic [3:0] is_sync;

  always_comb begin
    is_esc  = '0;
    is_idle = '0;
    is_sync = '0;
    for (int l = 0; l < 4; l++) begin
      is_esc[l]  = (data[l*LANE_W +: LANE_W] == ESC_CHAR);
      is_idle[l] = (data[l*LANE_W +: LANE_W] == IDLE_CHAR);
      is_sync[l] = (data[l*LANE_W+11 +: LANE_W-11] == SYNC_CHAR) &&
                   (data[l*LANE_W +: 11] == 11'd0);
    end
  end

  // Mixed-lane words never match a class, so they fall through to OTHER
  always_comb begin
    wclass = W_OTHER;
    if (&is_esc)       wclass = W_ESC;
    else if (&is_idle) wclass = W_IDLE;
    else if (&is_sync) wclass = W_SYNC;
  end

endmodule

// File: rtl/rx_train_detect192.sv
// RX training-preamble detector: ESC_CNT x ESC, IDLE_CNT x IDLE, SYNC_CNT x SYNC -> locked.
// Defining RX_TRAIN_ERR_CNT_EN adds a saturating seq_err counter on err_cnt.
//
//  state  | meaning
//  HUNT   | waiting for the first ESC word
//  ESC_S  | counting ESC words (extras tolerated)
//  IDLE_S | counting IDLE words
//  SYNC_S | counting SYNC words
//  LOCKED | preamble complete, data is payload
module rx_train_detect192 #(
  parameter int LANE_W   = pcs25g_train_pkg::LANE_W,
  parameter int ESC_CNT  = 4,
  parameter int IDLE_CNT = 4,
  parameter int SYNC_CNT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4*LANE_W-1:0] data,
  input  logic                in_rxen,
  input  logic                relock,
  output logic                locked,
  output logic                train_done,
  output logic                seq_err,
  output logic [2:0]          state
`ifdef RX_TRAIN_ERR_CNT_EN
  , output logic [15:0]       err_cnt
`endif
);
  import pcs25g_train_pkg::*;

  localparam logic [3:0] ESC_N     = 4'(ESC_CNT);
  localparam logic [3:0] IDLE_N    = 4'(IDLE_CNT);
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_CNT - 1);

  state_e      st;
  logic [3:0]  cnt;
  word_class_e wclass;

  train_word_classify192 #(.LANE_W(LANE_W)) u_classify (
    .data   (data),
    .wclass (wclass)
  );

  assign state = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= HUNT;
      cnt        <= '0;
      locked     <= 1'b0;
      train_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      train_done <= 1'b0;
      seq_err    <= 1'b0;
      if (relock) begin
        st     <= HUNT;
        cnt    <= '0;
        locked <= 1'b0;
      end else if (in_rxen) begin
        case (st)
          HUNT: begin
            if (wclass == W_ESC) begin
              st  <= ESC_S;
              cnt <= 4'd1;
            end
          end
          ESC_S: begin
            if (wclass == W_ESC) begin
              if (cnt < ESC_N) cnt <= cnt + 4'd1;
            end else if (wclass == W_IDLE && cnt == ESC_N) begin
              st  <= IDLE_S;
              cnt <= 4'd1;
            end else begin
              seq_err <= 1'b1;
              st      <= HUNT;
              cnt     <= '0;
            end
          end
          IDLE_S: begin
            if (wclass == W_IDLE && cnt < IDLE_N) begin
              cnt <= cnt + 4'd1;
            end else if (wclass == W_SYNC && cnt == IDLE_N) begin
              if (SYNC_CNT == 1) begin
                st         <= LOCKED;
                cnt        <= '0;
                locked     <= 1'b1;
                train_done <= 1'b1;
              end else begin
                st  <= SYNC_S;
                cnt <= 4'd1;
              end
            end else if (wclass == W_ESC) begin
              seq_err <= 1'b1;
              st      <= ESC_S;
              cnt     <= 4'd1;
            end else begin
              seq_err <= 1'b1;
              st      <= HUNT;
              cnt     <= '0;
            end
          end
          SYNC_S: begin
            // cnt holds the SYNC words already seen; lock is taken on the last one
            if (wclass == W_SYNC && cnt < SYNC_LAST) begin
              cnt <= cnt + 4'd1;
            end else if (wclass == W_SYNC && cnt == SYNC_LAST) begin
              st         <= LOCKED;
              cnt        <= '0;
              locked     <= 1'b1;
              train_done <= 1'b1;
            end else if (wclass == W_ESC) begin
              seq_err <= 1'b1;
              st      <= ESC_S;
              cnt     <= 4'd1;
            end else begin
              seq_err <= 1'b1;
              st      <= HUNT;
              cnt     <= '0;
            end
          end
          LOCKED: begin
          end
          default: begin
            st     <= HUNT;
            cnt    <= '0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RX_TRAIN_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (relock) begin
      err_cnt <= '0;
    end else if (seq_err && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
